// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-path constants, types and helpers
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - instruction buffer holding fetched {pc, inst} pairs in order
module if_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage: PC, imem request credit, response buffering, IF/ID register
module stage_if
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  br_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             keep;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign br_pc       = align_pc(br_target);
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

    // Every issued request reserves a buffer slot, so responses can never overflow.
    assign imem_req  = !rst && !br_taken && !fifo_full &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    // Responses to requests issued before a redirect are stale and discarded.
    assign keep       = imem_rvalid && !br_taken && (drop_cnt == '0);
    assign pop        = !br_taken && !ctrl_stall && !fifo_empty;
    assign push_entry = '{pc: rsp_pc, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (br_taken) begin
            pc <= br_pc;
        end else if (accept) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pc <= RESET_PC;
        end else if (br_taken) begin
            rsp_pc <= br_pc;
        end else if (keep) begin
            rsp_pc <= rsp_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, imem_rvalid})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (br_taken) begin
            drop_cnt <= imem_rvalid ? (outstanding - ONE) : outstanding;
        end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - ONE;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .flush (br_taken),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Redirect beats stall: the decode slot must not keep a wrong-path instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_inst  <= INST_NOP;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
        end else if (br_taken) begin
            if_inst  <= INST_NOP;
            if_valid <= 1'b0;
        end else if (!ctrl_stall) begin
            if (!fifo_empty) begin
                if_inst  <= head.inst;
                if_pc    <= head.pc;
                if_valid <= 1'b1;
            end else begin
                if_inst  <= INST_NOP;
                if_valid <= 1'b0;
            end
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (rst)
        credit_used <= (CNT_W+1)'(FIFO_DEPTH));
    a_drop:   assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);

endmodule
